// File: rtl/reservation_station_if.sv
`default_nettype none
// ============================================================================
// Module   : reservation_station_if
// Desc     : Issue, CDB snoop and dispatch bundle for reservation_station.
// Revision : 1.0 - initial release
// ============================================================================
interface reservation_station_if #(
    parameter int DEPTH  = 4,
    parameter int OP_W   = 6,
    parameter int TAG_W  = 5,
    parameter int DATA_W = 32
);
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    logic              issue_valid;
    logic              issue_ready;
    logic [OP_W-1:0]   issue_op;
    logic [TAG_W-1:0]  issue_dest;
    logic [TAG_W-1:0]  issue_tag_j;
    logic [TAG_W-1:0]  issue_tag_k;
    logic [DATA_W-1:0] issue_val_j;
    logic [DATA_W-1:0] issue_val_k;
    logic              cdb_broadcast;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_val;
    logic              disp_valid;
    logic              disp_ready;
    logic [OP_W-1:0]   disp_op;
    logic [TAG_W-1:0]  disp_dest;
    logic [DATA_W-1:0] disp_val_j;
    logic [DATA_W-1:0] disp_val_k;
    logic [c_CNT_W-1:0] count;

    modport master (
        output issue_valid, issue_op, issue_dest, issue_tag_j, issue_tag_k,
               issue_val_j, issue_val_k, cdb_broadcast, cdb_tag, cdb_val, disp_ready,
        input  issue_ready, disp_valid, disp_op, disp_dest, disp_val_j, disp_val_k, count
    );

    modport slave (
        input  issue_valid, issue_op, issue_dest, issue_tag_j, issue_tag_k,
               issue_val_j, issue_val_k, cdb_broadcast, cdb_tag, cdb_val, disp_ready,
        output issue_ready, disp_valid, disp_op, disp_dest, disp_val_j, disp_val_k, count
    );
endinterface
`default_nettype wire

// File: rtl/reservation_station.sv
`default_nettype none
// ============================================================================
// Module   : reservation_station
// Desc     : Tomasulo reservation station; snoops the CDB and dispatches the
//            oldest ready entry. Optional macro RS_CDB_BYPASS_EN captures a
//            same-cycle CDB broadcast at issue instead of stalling the issue.
// Revision : 1.0 - initial release
// ============================================================================
module reservation_station #(
    parameter int               DEPTH       = 4,
    parameter int               OP_W        = 6,
    parameter int               TAG_W       = 5,
    parameter int               DATA_W      = 32,
    parameter logic [TAG_W-1:0] INVALID_TAG = '1
) (
    input  wire logic            clk,
    input  wire logic            rst,
    reservation_station_if.slave bus
);
    localparam int c_IDX_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]   r_busy;
    logic [OP_W-1:0]    r_op    [DEPTH];
    logic [TAG_W-1:0]   r_dest  [DEPTH];
    logic [TAG_W-1:0]   r_tag_j [DEPTH];
    logic [DATA_W-1:0]  r_val_j [DEPTH];
    logic [TAG_W-1:0]   r_tag_k [DEPTH];
    logic [DATA_W-1:0]  r_val_k [DEPTH];
    logic [c_IDX_W-1:0] r_age   [DEPTH];
    logic [c_CNT_W-1:0] r_count;

    logic [DEPTH-1:0]   w_ready;
    logic               w_disp_valid;
    logic [c_IDX_W-1:0] w_sel;
    logic [c_IDX_W-1:0] w_sel_age;
    logic [c_IDX_W-1:0] w_free;
    logic [c_IDX_W-1:0] w_new_age;
    logic               w_cdb_hit;
    logic               w_issue_ready;
    logic               w_issue_fire;
    logic               w_disp_fire;
    logic [TAG_W-1:0]   w_new_tag_j;
    logic [TAG_W-1:0]   w_new_tag_k;
    logic [DATA_W-1:0]  w_new_val_j;
    logic [DATA_W-1:0]  w_new_val_k;

    assign w_cdb_hit = bus.cdb_broadcast && (bus.cdb_tag != INVALID_TAG);

    // Age 0 is the oldest entry; the oldest ready entry wins regardless of index.
    always_comb begin
        w_ready      = '0;
        w_disp_valid = 1'b0;
        w_sel        = '0;
        w_sel_age    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_ready[i] = r_busy[i] && (r_tag_j[i] == INVALID_TAG) && (r_tag_k[i] == INVALID_TAG);
            if (w_ready[i] && (!w_disp_valid || (r_age[i] < w_sel_age))) begin
                w_disp_valid = 1'b1;
                w_sel        = c_IDX_W'(i);
                w_sel_age    = r_age[i];
            end
        end
    end

    always_comb begin
        w_free = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                w_free = c_IDX_W'(i);
            end
        end
    end

    always_comb begin
        w_new_tag_j = bus.issue_tag_j;
        w_new_val_j = bus.issue_val_j;
        w_new_tag_k = bus.issue_tag_k;
        w_new_val_k = bus.issue_val_k;
`ifdef RS_CDB_BYPASS_EN
        if (w_cdb_hit && (bus.issue_tag_j == bus.cdb_tag)) begin
            w_new_tag_j = INVALID_TAG;
            w_new_val_j = bus.cdb_val;
        end
        if (w_cdb_hit && (bus.issue_tag_k == bus.cdb_tag)) begin
            w_new_tag_k = INVALID_TAG;
            w_new_val_k = bus.cdb_val;
        end
`endif
    end

`ifdef RS_CDB_BYPASS_EN
    assign w_issue_ready = (r_count != c_CNT_W'(DEPTH));
`else
    // Without bypass an issue whose producer broadcasts this cycle would miss its wakeup.
    assign w_issue_ready = (r_count != c_CNT_W'(DEPTH)) &&
                           !(w_cdb_hit && ((bus.issue_tag_j == bus.cdb_tag) ||
                                           (bus.issue_tag_k == bus.cdb_tag)));
`endif

    assign w_issue_fire = bus.issue_valid && w_issue_ready;
    assign w_disp_fire  = w_disp_valid && bus.disp_ready;
    assign w_new_age    = c_IDX_W'(r_count - c_CNT_W'(w_disp_fire));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy  <= '0;
            r_count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r_busy[i] && w_cdb_hit) begin
                    if (r_tag_j[i] == bus.cdb_tag) begin
                        r_tag_j[i] <= INVALID_TAG;
                        r_val_j[i] <= bus.cdb_val;
                    end
                    if (r_tag_k[i] == bus.cdb_tag) begin
                        r_tag_k[i] <= INVALID_TAG;
                        r_val_k[i] <= bus.cdb_val;
                    end
                end
                if (w_disp_fire && r_busy[i] && (r_age[i] > w_sel_age)) begin
                    r_age[i] <= r_age[i] - c_IDX_W'(1);
                end
            end
            if (w_disp_fire) begin
                r_busy[w_sel] <= 1'b0;
            end
            if (w_issue_fire) begin
                r_busy[w_free]  <= 1'b1;
                r_op[w_free]    <= bus.issue_op;
                r_dest[w_free]  <= bus.issue_dest;
                r_tag_j[w_free] <= w_new_tag_j;
                r_val_j[w_free] <= w_new_val_j;
                r_tag_k[w_free] <= w_new_tag_k;
                r_val_k[w_free] <= w_new_val_k;
                r_age[w_free]   <= w_new_age;
            end
            case ({w_issue_fire, w_disp_fire})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.issue_ready = w_issue_ready;
    assign bus.disp_valid  = w_disp_valid;
    assign bus.disp_op     = r_op[w_sel];
    assign bus.disp_dest   = r_dest[w_sel];
    assign bus.disp_val_j  = r_val_j[w_sel];
    assign bus.disp_val_k  = r_val_k[w_sel];
    assign bus.count       = r_count;
endmodule
`default_nettype wire

// File: tb/tb_reservation_station.sv
`default_nettype none
// ============================================================================
// Module   : tb_reservation_station
// Desc     : Scoreboard bench for reservation_station against an in-order
//            queue model; honours RS_CDB_BYPASS_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reservation_station;
    localparam int         DEPTH  = 4;
    localparam int         OP_W   = 6;
    localparam int         TAG_W  = 5;
    localparam int         DATA_W = 32;
    localparam logic [4:0] INV    = 5'b11111;

    typedef struct {
        logic [5:0]  op;
        logic [4:0]  dest;
        logic [4:0]  tj;
        logic [4:0]  tk;
        logic [31:0] vj;
        logic [31:0] vk;
    } ent_t;

    typedef struct {
        bit          ir;
        bit          dv;
        int          cnt;
        logic [5:0]  op;
        logic [4:0]  dest;
        logic [31:0] vj;
        logic [31:0] vk;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    ent_t rs_q[$];
    exp_t exp_q[$];

    always #5 clk = ~clk;

    reservation_station_if #(.DEPTH(DEPTH), .OP_W(OP_W), .TAG_W(TAG_W), .DATA_W(DATA_W)) bus();

    reservation_station #(
        .DEPTH(DEPTH), .OP_W(OP_W), .TAG_W(TAG_W), .DATA_W(DATA_W), .INVALID_TAG(INV)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive inputs, predict this cycle's outputs, then advance the model past the edge.
    task automatic step(input bit r, input bit iv, input logic [5:0] op, input logic [4:0] dest,
                        input logic [4:0] tj, input logic [4:0] tk, input logic [31:0] vj,
                        input logic [31:0] vk, input bit bc, input logic [4:0] ct,
                        input logic [31:0] cv, input bit dr);
        exp_t e;
        ent_t n;
        ent_t t;
        int   idx;
        bit   hit;
        @(negedge clk);
        rst               = r;
        bus.issue_valid   = iv;
        bus.issue_op      = op;
        bus.issue_dest    = dest;
        bus.issue_tag_j   = tj;
        bus.issue_tag_k   = tk;
        bus.issue_val_j   = vj;
        bus.issue_val_k   = vk;
        bus.cdb_broadcast = bc;
        bus.cdb_tag       = ct;
        bus.cdb_val       = cv;
        bus.disp_ready    = dr;

        hit   = bc && (ct != INV);
        e     = '{default: 0};
        e.cnt = rs_q.size();
`ifdef RS_CDB_BYPASS_EN
        e.ir  = (rs_q.size() != DEPTH);
`else
        e.ir  = (rs_q.size() != DEPTH) && !(hit && (tj == ct || tk == ct));
`endif
        idx = -1;
        foreach (rs_q[i]) begin
            if (idx < 0 && rs_q[i].tj == INV && rs_q[i].tk == INV) idx = i;
        end
        if (idx >= 0) begin
            e.dv   = 1'b1;
            e.op   = rs_q[idx].op;
            e.dest = rs_q[idx].dest;
            e.vj   = rs_q[idx].vj;
            e.vk   = rs_q[idx].vk;
        end
        exp_q.push_back(e);

        if (r) begin
            rs_q.delete();
        end else begin
            if (hit) begin
                foreach (rs_q[i]) begin
                    t = rs_q[i];
                    if (t.tj == ct) begin t.tj = INV; t.vj = cv; end
                    if (t.tk == ct) begin t.tk = INV; t.vk = cv; end
                    rs_q[i] = t;
                end
            end
            if (idx >= 0 && dr) rs_q.delete(idx);
            if (iv && e.ir) begin
                n = '{op: op, dest: dest, tj: tj, tk: tk, vj: vj, vk: vk};
`ifdef RS_CDB_BYPASS_EN
                if (hit && tj == ct) begin n.tj = INV; n.vj = cv; end
                if (hit && tk == ct) begin n.tk = INV; n.vk = cv; end
`endif
                rs_q.push_back(n);
            end
        end
    endtask

    task automatic idle(input bit dr);
        step(0, 0, 6'd0, 5'd0, INV, INV, 32'd0, 32'd0, 0, INV, 32'd0, dr);
    endtask

    task automatic iss(input logic [5:0] op, input logic [4:0] dest, input logic [4:0] tj,
                       input logic [4:0] tk, input logic [31:0] vj, input logic [31:0] vk,
                       input bit dr);
        step(0, 1, op, dest, tj, tk, vj, vk, 0, INV, 32'd0, dr);
    endtask

    task automatic bcast(input logic [4:0] ct, input logic [31:0] cv, input bit dr);
        step(0, 0, 6'd0, 5'd0, INV, INV, 32'd0, 32'd0, 1, ct, cv, dr);
    endtask

    function automatic logic [4:0] rtag();
        int v;
        v = $urandom_range(0, 8);
        return (v == 8) ? INV : 5'(v);
    endfunction

    // Monitor: compares each cycle's outputs against the queued prediction.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() != 0) begin
                x = exp_q.pop_front();
                chk("issue_ready", 32'(bus.issue_ready), 32'(x.ir));
                chk("count", 32'(bus.count), 32'(x.cnt));
                chk("disp_valid", 32'(bus.disp_valid), 32'(x.dv));
                if (x.dv && bus.disp_valid) begin
                    chk("disp_op", 32'(bus.disp_op), 32'(x.op));
                    chk("disp_dest", 32'(bus.disp_dest), 32'(x.dest));
                    chk("disp_val_j", bus.disp_val_j, x.vj);
                    chk("disp_val_k", bus.disp_val_k, x.vk);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.issue_valid   = 1'b0;
        bus.issue_op      = '0;
        bus.issue_dest    = '0;
        bus.issue_tag_j   = INV;
        bus.issue_tag_k   = INV;
        bus.issue_val_j   = '0;
        bus.issue_val_k   = '0;
        bus.cdb_broadcast = 1'b0;
        bus.cdb_tag       = INV;
        bus.cdb_val       = '0;
        bus.disp_ready    = 1'b0;
        repeat (2) @(posedge clk);

        // Ready-at-issue entry dispatches one cycle later.
        idle(1);
        iss(6'd3, 5'd2, INV, INV, 32'd5, 32'd7, 1);
        idle(1);
        idle(1);

        // CDB wakeup of a single operand.
        iss(6'd1, 5'd3, 5'd4, INV, 32'd0, 32'd9, 1);
        bcast(5'd4, 32'hDEADBEEF, 1);
        idle(1);
        idle(1);

        // Fill the station, then release every entry with one broadcast.
        for (int i = 0; i < DEPTH; i++) iss(6'(10 + i), 5'(i), 5'd9, INV, 32'd0, 32'(i), 1);
        idle(1);
        bcast(5'd9, 32'h1234, 1);
        repeat (5) idle(1);

        // Younger ready entry goes before an older waiting one.
        iss(6'd20, 5'd5, 5'd1, INV, 32'd0, 32'd1, 0);
        iss(6'd21, 5'd6, INV, INV, 32'd2, 32'd3, 0);
        idle(0);
        idle(0);
        bcast(5'd1, 32'h55, 1);
        repeat (3) idle(1);

        // Issue colliding with a broadcast of its own producer tag.
        step(0, 1, 6'd7, 5'd8, INV, 5'd6, 32'd1, 32'd0, 1, 5'd6, 32'd11, 1);
        step(0, 1, 6'd7, 5'd8, INV, 5'd6, 32'd1, 32'd0, 0, INV, 32'd0, 1);
        idle(1);
        bcast(5'd6, 32'd11, 1);
        repeat (3) idle(1);

        // Reset discards pending entries; their tags later wake nothing.
        iss(6'd30, 5'd1, 5'd12, INV, 32'd0, 32'd0, 0);
        iss(6'd31, 5'd2, 5'd13, INV, 32'd0, 32'd0, 0);
        iss(6'd32, 5'd3, INV, 5'd14, 32'd0, 32'd0, 0);
        step(1, 0, 6'd0, 5'd0, INV, INV, 32'd0, 32'd0, 0, INV, 32'd0, 1);
        idle(1);
        bcast(5'd12, 32'd1, 1);
        bcast(5'd13, 32'd2, 1);
        bcast(5'd14, 32'd3, 1);
        repeat (2) idle(1);

        for (int c = 0; c < 800; c++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 9) < 6),
                 6'($urandom), 5'($urandom), rtag(), rtag(), $urandom, $urandom,
                 ($urandom_range(0, 9) < 4), rtag(), $urandom,
                 ($urandom_range(0, 9) < 7));
        end
        repeat (6) idle(1);

        @(negedge clk);
        #4;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
